// File: rtl/nap_countdown_pkg.sv
// Shared types and constants for the nap-time countdown: state encoding,
// BCD digit type and the load-validity check.
package nap_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_SEC  = 4'd9;
  localparam bcd_t MAX_TENS = 4'd5;
  localparam bcd_t MAX_MIN  = 4'd9;

  // A loadable time has every digit in range and is not 0:00.
  function automatic logic load_ok(input bcd_t s, input bcd_t t, input bcd_t m);
    return (s <= MAX_SEC) && (t <= MAX_TENS) && (m <= MAX_MIN) &&
           ({m, t, s} != 12'd0);
  endfunction

endpackage

// File: rtl/nap_countdown_tick_prescaler.sv
// Free-running divider: emits a one-cycle tick on every TICKS-th enabled cycle.
// The count holds while enable is low; clear returns it to zero.
module tick_prescaler #(
  parameter int TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Combinational so the owner can act on the wrap edge itself.
  assign tick = enable && (count == LAST);

endmodule

// File: rtl/nap_countdown.sv
// Nap-time countdown: loads a BCD m:ss time, counts it down once a second,
// then holds an alarm until stop or until ALARM_SECS seconds have passed.
module nap_countdown
  import nap_countdown_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000000,
  parameter int ALARM_SECS    = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       completeSetting,
  input  logic [3:0] one_sec_in,
  input  logic [3:0] ten_sec_in,
  input  logic [3:0] one_min_in,
  input  logic       pause,
  input  logic       stop,
  output logic [3:0] one_sec,
  output logic [3:0] ten_sec,
  output logic [3:0] one_min,
  output logic       running,
  output logic       alarm,
  output logic       done,
  output logic       load_err,
  output logic [1:0] state_dbg
);

  localparam int AW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  state_t        state;
  logic [AW-1:0] alarm_secs;
  logic          sec_tick, alarm_tick;
  logic          sec_clear, alarm_clear;
  logic          accept, reject, final_tick;
  bcd_t          dec_sec, dec_ten, dec_min;

  // completeSetting is a one-cycle strobe with its digits valid in that same
  // cycle; there is no back-pressure. stop outranks it, so a strobe that
  // coincides with stop is neither accepted nor reported as an error.
  assign accept = completeSetting && !stop &&  load_ok(one_sec_in, ten_sec_in, one_min_in);
  assign reject = completeSetting && !stop && !load_ok(one_sec_in, ten_sec_in, one_min_in);

  assign final_tick = (one_min == '0) && (ten_sec == '0) && (one_sec == 4'd1);

  always_comb begin
    dec_sec = one_sec - 4'd1;
    dec_ten = ten_sec;
    dec_min = one_min;
    if (one_sec == '0) begin
      dec_sec = MAX_SEC;
      if (ten_sec == '0) begin
        dec_ten = MAX_TENS;
        dec_min = one_min - 4'd1;
      end else begin
        dec_ten = ten_sec - 4'd1;
      end
    end
  end

  // The countdown prescaler only advances in RUN; PAUSED holds its phase.
  assign sec_clear   = accept || (state == ST_IDLE) || (state == ST_ALARM);
  assign alarm_clear = accept || (state != ST_ALARM);

  tick_prescaler #(.TICKS(TICKS_PER_SEC)) u_sec_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (sec_clear),
    .enable (state == ST_RUN),
    .tick   (sec_tick)
  );

  tick_prescaler #(.TICKS(TICKS_PER_SEC)) u_alarm_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (alarm_clear),
    .enable (state == ST_ALARM),
    .tick   (alarm_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      one_sec    <= '0;
      ten_sec    <= '0;
      one_min    <= '0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
      alarm_secs <= '0;
    end else begin
      done     <= 1'b0;
      load_err <= reject;
      if (stop) begin
        state      <= ST_IDLE;
        one_sec    <= '0;
        ten_sec    <= '0;
        one_min    <= '0;
        running    <= 1'b0;
        alarm      <= 1'b0;
        alarm_secs <= '0;
      end else if (accept) begin
        // A load discards any tick landing on the same edge.
        one_sec    <= one_sec_in;
        ten_sec    <= ten_sec_in;
        one_min    <= one_min_in;
        state      <= (state != ST_IDLE && pause) ? ST_PAUSED : ST_RUN;
        running    <= 1'b1;
        alarm      <= 1'b0;
        alarm_secs <= '0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_RUN: begin
            if (sec_tick) begin
              one_sec <= dec_sec;
              ten_sec <= dec_ten;
              one_min <= dec_min;
              if (final_tick) begin
                state   <= ST_ALARM;
                running <= 1'b0;
                alarm   <= 1'b1;
                done    <= 1'b1;
              end else if (pause) begin
                state <= ST_PAUSED;
              end
            end else if (pause) begin
              state <= ST_PAUSED;
            end
          end
          ST_PAUSED: begin
            if (!pause) state <= ST_RUN;
          end
          ST_ALARM: begin
            if (alarm_tick) begin
              if (alarm_secs == ALARM_LAST) begin
                state      <= ST_IDLE;
                alarm      <= 1'b0;
                alarm_secs <= '0;
              end else begin
                alarm_secs <= alarm_secs + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/nap_countdown.md
Name: nap_countdown

Overview:
- Consumer end of the nap-time setting interface: captures the BCD time (minutes, tens of seconds, seconds) when the setting completes, then counts it down once per second.
- Raises an alarm at 0:00; the alarm holds until acknowledged or until it times out.
- Sits between the keypad time-selection FSM and the display/buzzer drivers.

Parameters:
- TICKS_PER_SEC, 1000000: clock cycles per one-second tick of the internal prescaler (minimum 2).
- ALARM_SECS, 10: seconds the alarm stays asserted before returning to idle on its own.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- completeSetting  in  1  one-cycle load strobe from the setting FSM
- one_sec_in  in  4  BCD seconds digit to load, valid when completeSetting=1
- ten_sec_in  in  4  BCD tens-of-seconds digit to load
- one_min_in  in  4  BCD minutes digit to load
- pause  in  1  level; while 1 in RUN, the countdown and prescaler freeze
- stop  in  1  one-cycle cancel/acknowledge
- one_sec  out  4  remaining seconds digit (BCD)
- ten_sec  out  4  remaining tens-of-seconds digit (BCD)
- one_min  out  4  remaining minutes digit (BCD)
- running  out  1  1 in RUN and PAUSED
- alarm  out  1  1 in ALARM
- done  out  1  one-cycle pulse on entry to ALARM
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - State goes to IDLE; all digits 0; running, alarm, done and load_err all 0; prescaler and alarm-second counter cleared.
  - A reset during RUN or ALARM aborts the operation at that edge.
- States are IDLE, RUN, PAUSED and ALARM. All outputs are registered.
- Load validity: a load is valid only if one_sec_in<=9, ten_sec_in<=5, one_min_in<=9, and the value is not 0:00.
  - An invalid load leaves state and digits unchanged and pulses load_err for one cycle.
- IDLE:
  - A valid completeSetting captures the digits and enters RUN at the next edge; the prescaler clears.
  - The loaded digits appear on the outputs in the cycle after the strobe.
- RUN:
  - The prescaler counts 0..TICKS_PER_SEC-1; a tick occurs at wrap. The first tick comes TICKS_PER_SEC cycles after the load edge.
  - Each tick decrements the time as BCD with borrow. A seconds digit of 0 becomes 9 and borrows from ten_sec. A ten_sec of 0 becomes 5 and borrows from one_min.
  - The tick that produces 0:00 also moves to ALARM on the same edge, and done pulses.
- PAUSED:
  - Entered from RUN when pause=1; returns to RUN when pause=0.
  - The prescaler value is held, so elapsed partial seconds are kept.
  - running stays 1.
- ALARM:
  - alarm=1 and the digits read 0:00.
  - A separate counter measures ALARM_SECS seconds; when it expires the block goes to IDLE.
  - stop also goes to IDLE at the next edge.
- stop in RUN or PAUSED: go to IDLE, digits clear to 0, no done pulse.
- Simultaneous events:
  - stop has priority over completeSetting.
  - A valid completeSetting in RUN, PAUSED or ALARM restarts: it reloads, clears the prescaler, enters RUN (or PAUSED if pause=1), and drops alarm.
  - completeSetting on the same edge as a tick: the load wins and the tick is discarded.
  - pause on the same cycle as the final tick: the tick is processed and ALARM is entered.
- Width rules: the prescaler is $clog2(TICKS_PER_SEC) bits and the alarm-second counter is $clog2(ALARM_SECS+1) bits. The digits never leave the BCD range.

Decomposition:
- Shared package holds the state encoding (IDLE, RUN, PAUSED, ALARM as a 2-bit enum), the BCD digit type, and the constants MAX_SEC=9, MAX_TENS=5, MAX_MIN=9.
- One natural sub-module, tick_prescaler: a counter with clear and enable inputs that emits a one-cycle tick every TICKS_PER_SEC enabled cycles. The top instantiates it twice, once for the countdown and once for the alarm timeout.

Test Plan:
- TICKS_PER_SEC=4, ALARM_SECS=2. Reset, then load 0:05.
  - Required: digits read 0:05 in the cycle after the strobe, then decrement every 4 cycles.
  - done pulses exactly 20 cycles after the load edge; alarm holds 8 cycles, then the block returns to IDLE.
- Load 1:00, wait one tick.
  - Required: digits read 0:59 (one_min=0, ten_sec=5, one_sec=9); on the next tick, 0:58.
- Load 0:30, hold pause for 10 cycles midway through a second.
  - Required: digits and prescaler frozen; on resume, the remaining partial second completes; running=1 throughout.
- Loads rejected:
  - ten_sec_in=6 or 0:00 loaded in IDLE gives a single load_err pulse; state stays IDLE and digits stay 0.
  - A valid 0:05 load during ALARM drops alarm and restarts RUN at 0:05.
- stop and completeSetting asserted together in RUN: the block goes to IDLE, digits read 0, and there is no done pulse.
- Reset asserted in ALARM: all outputs read 0 at the next edge; a subsequent load behaves normally.
